// File: rtl/pid_cfg_loader.sv
// UART configuration loader for the pid register port: receives 8N1 frames
// (A5, ADDR, DATA_H, DATA_L, CHK), validates them and issues one register write.
//
// Receiver FSM
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a synchronized low
//   RX_START | counting to the start-bit centre, rejecting glitches
//   RX_DATA  | sampling 8 data bits LSB first at bit centres
//   RX_STOP  | sampling the stop bit; 1 delivers the byte, 0 is a framing error
//
// Parser FSM
//   state    | meaning
//   P_HUNT   | waiting for the 0xA5 sync byte, everything else ignored
//   P_ADDR   | next byte is the register address
//   P_DH     | next byte is the data high byte
//   P_DL     | next byte is the data low byte
//   P_CHK    | next byte is the checksum; commit or reject, then HUNT

module pid_cfg_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int NUM_REGS     = 4,
  parameter int TIMEOUT_CLKS = 512
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic        write_enable,
  output logic [15:0] reg_addr,
  output logic [15:0] reg_data,
  output logic        busy,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] BIT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CLKS - 1);
  localparam logic [8:0]    NUM_REGS_L = 9'(NUM_REGS);
  localparam logic [7:0]    SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    P_HUNT,
    P_ADDR,
    P_DH,
    P_DL,
    P_CHK
  } p_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer (idles high so reset never looks like a start bit)
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  rx_state_t     rx_state;
  rx_state_t     rx_next;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] bit_cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift_q;
  logic [7:0]    shift_next;
  logic          bv_next;
  logic          fb_next;
  logic          byte_valid;
  logic          frame_bad;
  logic [7:0]    rx_byte;

  always_comb begin
    rx_next      = rx_state;
    bit_cnt_next = bit_cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift_q;
    bv_next      = 1'b0;
    fb_next      = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_next      = RX_START;
          bit_cnt_next = BIT_HALF;
        end
      end
      RX_START: begin
        if (bit_cnt == '0) begin
          if (rx_sync) begin
            rx_next = RX_IDLE;
          end else begin
            rx_next      = RX_DATA;
            bit_cnt_next = BIT_FULL;
            bit_idx_next = 3'd0;
          end
        end else begin
          bit_cnt_next = bit_cnt - CW'(1);
        end
      end
      RX_DATA: begin
        if (bit_cnt == '0) begin
          shift_next   = {rx_sync, shift_q[7:1]};
          bit_cnt_next = BIT_FULL;
          if (bit_idx == 3'd7) begin
            rx_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_next = bit_cnt - CW'(1);
        end
      end
      RX_STOP: begin
        if (bit_cnt == '0) begin
          rx_next = RX_IDLE;
          if (rx_sync) begin
            bv_next = 1'b1;
          end else begin
            fb_next = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt - CW'(1);
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_q    <= 8'h00;
      byte_valid <= 1'b0;
      frame_bad  <= 1'b0;
      rx_byte    <= 8'h00;
    end else begin
      rx_state   <= rx_next;
      bit_cnt    <= bit_cnt_next;
      bit_idx    <= bit_idx_next;
      shift_q    <= shift_next;
      byte_valid <= bv_next;
      frame_bad  <= fb_next;
      if (bv_next) begin
        rx_byte <= shift_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame parser
  // ---------------------------------------------------------------------------
  p_state_t      p_state;
  p_state_t      p_next;
  logic [7:0]    addr_q;
  logic [7:0]    dh_q;
  logic [7:0]    dl_q;
  logic [TW-1:0] tmr;
  logic          chk_ok;
  logic          do_commit;
  logic          do_err;

  assign chk_ok = (rx_byte == (addr_q ^ dh_q ^ dl_q)) && ({1'b0, addr_q} < NUM_REGS_L);

  // Priority: framing error, then a received byte, then timeout. A byte and a
  // timeout in the same cycle resolve as the byte.
  always_comb begin
    p_next    = p_state;
    do_commit = 1'b0;
    do_err    = 1'b0;
    if (frame_bad) begin
      do_err = (p_state != P_HUNT);
      p_next = P_HUNT;
    end else if (byte_valid) begin
      case (p_state)
        P_HUNT: if (rx_byte == SYNC_BYTE) p_next = P_ADDR;
        P_ADDR: p_next = P_DH;
        P_DH:   p_next = P_DL;
        P_DL:   p_next = P_CHK;
        P_CHK: begin
          do_commit = chk_ok;
          do_err    = !chk_ok;
          p_next    = P_HUNT;
        end
        default: p_next = P_HUNT;
      endcase
    end else if ((p_state != P_HUNT) && (tmr == '0)) begin
      do_err = 1'b1;
      p_next = P_HUNT;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_state <= P_HUNT;
      addr_q  <= 8'h00;
      dh_q    <= 8'h00;
      dl_q    <= 8'h00;
      tmr     <= TMO_LOAD;
    end else begin
      p_state <= p_next;
      if (byte_valid) begin
        case (p_state)
          P_ADDR:  addr_q <= rx_byte;
          P_DH:    dh_q   <= rx_byte;
          P_DL:    dl_q   <= rx_byte;
          default: ;
        endcase
      end
      if (byte_valid || (p_state == P_HUNT)) begin
        tmr <= TMO_LOAD;
      end else if (tmr != '0) begin
        tmr <= tmr - TW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Register write port and error reporting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_enable <= 1'b1;
      reg_addr     <= 16'h0000;
      reg_data     <= 16'h0000;
      frame_err    <= 1'b0;
      err_count    <= 8'h00;
    end else begin
      write_enable <= !do_commit;
      frame_err    <= do_err;
      if (do_commit) begin
        reg_addr <= {8'h00, addr_q};
        reg_data <= {dh_q, dl_q};
      end
      if (do_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign busy = (p_state != P_HUNT);

endmodule

// File: tb/tb_pid_cfg_loader.sv
// Directed bench for pid_cfg_loader: a main instance at 16 clocks/bit and a
// fast 4 clocks/bit instance used only for err_count saturation.

module tb_pid_cfg_loader;

  localparam int CPB   = 16;
  localparam int CPB_S = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic        rx_s;
  logic        write_enable;
  logic [15:0] reg_addr;
  logic [15:0] reg_data;
  logic        busy;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        write_enable_s;
  logic [15:0] reg_addr_s;
  logic [15:0] reg_data_s;
  logic        busy_s;
  logic        frame_err_s;
  logic [7:0]  err_count_s;

  always #5 clock = ~clock;

  pid_cfg_loader #(.CLKS_PER_BIT(CPB), .NUM_REGS(4), .TIMEOUT_CLKS(512)) dut (
    .clock(clock), .reset(reset), .rx(rx),
    .write_enable(write_enable), .reg_addr(reg_addr), .reg_data(reg_data),
    .busy(busy), .frame_err(frame_err), .err_count(err_count)
  );

  pid_cfg_loader #(.CLKS_PER_BIT(CPB_S), .NUM_REGS(4), .TIMEOUT_CLKS(512)) dut_s (
    .clock(clock), .reset(reset), .rx(rx_s),
    .write_enable(write_enable_s), .reg_addr(reg_addr_s), .reg_data(reg_data_s),
    .busy(busy_s), .frame_err(frame_err_s), .err_count(err_count_s)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Write / error event monitor for the main instance
  int          we_cnt  = 0;
  int          we_long = 0;
  int          fe_cnt  = 0;
  bit          we_prev = 1'b0;
  logic [15:0] we_addr = 16'h0;
  logic [15:0] we_data = 16'h0;

  always @(negedge clock) begin
    if (write_enable === 1'b0) begin
      we_cnt++;
      we_addr = reg_addr;
      we_data = reg_data;
      if (we_prev) we_long++;
    end
    we_prev = (write_enable === 1'b0);
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_s = v;
    else     rx   = v;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop_val,
                           input int stop_len);
    int cpb;
    cpb = sel ? CPB_S : CPB;
    @(negedge clock);
    drive(sel, 1'b0);
    repeat (cpb) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      drive(sel, b[i]);
      repeat (cpb) @(negedge clock);
    end
    drive(sel, stop_val);
    repeat (stop_len) @(negedge clock);
    if (stop_len != 0) drive(sel, 1'b1);
  endtask

  task automatic send_ok(input bit sel, input logic [7:0] b);
    send_byte(sel, b, 1'b1, sel ? CPB_S : CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    send_ok(sel, b0);
    send_ok(sel, b1);
    send_ok(sel, b2);
    send_ok(sel, b3);
    send_ok(sel, b4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wait_clks(3);
    reset = 1'b1;
    wait_clks(2);
  endtask

  initial begin
    int  we0;
    int  fe0;
    int  n;
    bit  found;
    bit  low_seen;

    reset = 1'b0;
    rx    = 1'b1;
    rx_s  = 1'b1;
    wait_clks(3);
    check("rst_we",    write_enable, 1);
    check("rst_addr",  reg_addr,     0);
    check("rst_data",  reg_data,     0);
    check("rst_busy",  busy,         0);
    check("rst_ferr",  frame_err,    0);
    check("rst_ecnt",  err_count,    0);
    reset = 1'b1;
    wait_clks(2);

    // Valid frame
    we0 = we_cnt; fe0 = fe_cnt;
    send_ok(0, 8'hA5);
    wait_clks(2);
    check("busy_after_sync", busy, 1);
    send_ok(0, 8'h01); send_ok(0, 8'h00); send_ok(0, 8'h0D); send_ok(0, 8'h0C);
    wait_clks(4);
    check("v1_writes",  we_cnt - we0, 1);
    check("v1_addr",    we_addr, 16'h0001);
    check("v1_data",    we_data, 16'h000D);
    check("v1_ferr",    fe_cnt - fe0, 0);
    check("v1_ecnt",    err_count, 0);
    check("v1_busy",    busy, 0);
    check("v1_we_long", we_long, 0);

    // Hunt garbage, then 0xA5 as a data byte
    we0 = we_cnt; fe0 = fe_cnt;
    send_ok(0, 8'h00); send_ok(0, 8'hFF);
    wait_clks(4);
    check("hunt_busy", busy, 0);
    send_frame(0, 8'hA5, 8'h02, 8'hA5, 8'h00, 8'hA7);
    wait_clks(4);
    check("v2_writes", we_cnt - we0, 1);
    check("v2_addr",   we_addr, 16'h0002);
    check("v2_data",   we_data, 16'hA500);
    check("v2_ferr",   fe_cnt - fe0, 0);
    check("v2_ecnt",   err_count, 0);

    // Bad checksum, then bad address
    we0 = we_cnt; fe0 = fe_cnt;
    send_frame(0, 8'hA5, 8'h03, 8'h12, 8'h34, 8'h00);
    wait_clks(4);
    check("chk_writes", we_cnt - we0, 0);
    check("chk_ferr",   fe_cnt - fe0, 1);
    check("chk_ecnt",   err_count, 1);
    check("chk_addr",   reg_addr, 16'h0002);
    check("chk_data",   reg_data, 16'hA500);
    send_frame(0, 8'hA5, 8'h07, 8'h00, 8'h01, 8'h06);
    wait_clks(4);
    check("adr_writes", we_cnt - we0, 0);
    check("adr_ferr",   fe_cnt - fe0, 2);
    check("adr_ecnt",   err_count, 2);
    check("adr_addr",   reg_addr, 16'h0002);

    // Timeout: error expected 512 clocks after the second byte is delivered
    do_reset();
    we0 = we_cnt; fe0 = fe_cnt;
    send_ok(0, 8'hA5); send_ok(0, 8'h01);
    found = 1'b0; n = 0;
    for (int i = 1; i <= 600; i++) begin
      @(negedge clock);
      if (frame_err && !found) begin
        found = 1'b1;
        n = i;
      end
    end
    check("tmo_seen",   found, 1);
    check("tmo_window", (n >= 500 && n <= 516), 1);
    check("tmo_busy",   busy, 0);
    check("tmo_ecnt",   err_count, 1);
    check("tmo_ferr",   fe_cnt - fe0, 1);
    send_frame(0, 8'hA5, 8'h00, 8'h00, 8'h0E, 8'h0E);
    wait_clks(4);
    check("tmo_next_writes", we_cnt - we0, 1);
    check("tmo_next_addr",   we_addr, 16'h0000);
    check("tmo_next_data",   we_data, 16'h000E);

    // Framing error mid-frame, then a short start-bit glitch
    do_reset();
    we0 = we_cnt; fe0 = fe_cnt;
    send_ok(0, 8'hA5);
    send_byte(0, 8'h01, 1'b0, CPB);
    wait_clks(60);
    check("fe_ecnt",   err_count, 1);
    check("fe_ferr",   fe_cnt - fe0, 1);
    check("fe_busy",   busy, 0);
    check("fe_writes", we_cnt - we0, 0);
    fe0 = fe_cnt;
    rx = 1'b0;
    wait_clks(3);
    rx = 1'b1;
    wait_clks(40);
    check("glitch_ferr", fe_cnt - fe0, 0);
    check("glitch_ecnt", err_count, 1);
    check("glitch_busy", busy, 0);
    we0 = we_cnt;
    send_frame(0, 8'hA5, 8'h02, 8'h00, 8'h05, 8'h07);
    wait_clks(4);
    check("post_glitch_writes", we_cnt - we0, 1);
    check("post_glitch_data",   we_data, 16'h0005);

    // Reset during the write strobe
    do_reset();
    send_ok(0, 8'hA5); send_ok(0, 8'h01); send_ok(0, 8'h00); send_ok(0, 8'h0D);
    send_byte(0, 8'h0C, 1'b1, 0);
    low_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (write_enable === 1'b0) begin
        low_seen = 1'b1;
        break;
      end
    end
    check("mw_low_seen", low_seen, 1);
    #1 reset = 1'b0;
    #1 check("mw_async_we", write_enable, 1);
    wait_clks(2);
    check("mw_addr", reg_addr, 0);
    check("mw_data", reg_data, 0);
    reset = 1'b1;
    wait_clks(2);

    // Reset mid-frame
    send_frame(0, 8'hA5, 8'h01, 8'h00, 8'h0D, 8'h0C);
    send_frame(0, 8'hA5, 8'h03, 8'h12, 8'h34, 8'h00);
    send_ok(0, 8'hA5); send_ok(0, 8'h01); send_ok(0, 8'h00);
    wait_clks(2);
    check("mf_pre_busy", busy, 1);
    check("mf_pre_ecnt", err_count, 1);
    reset = 1'b0;
    wait_clks(2);
    check("mf_we",   write_enable, 1);
    check("mf_addr", reg_addr, 0);
    check("mf_data", reg_data, 0);
    check("mf_busy", busy, 0);
    check("mf_ferr", frame_err, 0);
    check("mf_ecnt", err_count, 0);
    reset = 1'b1;
    wait_clks(2);
    we0 = we_cnt;
    send_frame(0, 8'hA5, 8'h01, 8'h00, 8'h0D, 8'h0C);
    wait_clks(4);
    check("mf_next_writes", we_cnt - we0, 1);
    check("mf_next_addr",   we_addr, 16'h0001);
    check("mf_next_data",   we_data, 16'h000D);
    check("mf_next_ecnt",   err_count, 0);

    // err_count saturation on the fast instance
    for (int k = 0; k < 300; k++) begin
      send_frame(1, 8'hA5, 8'h03, 8'h12, 8'h34, 8'h00);
      if (k == 199) begin
        wait_clks(4);
        check("sat_200", err_count_s, 200);
      end
    end
    wait_clks(4);
    check("sat_255",    err_count_s, 255);
    check("sat_writes", write_enable_s, 1);
    check("sat_addr",   reg_addr_s, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pid_cfg_loader.md
# pid_cfg_loader

Serial configuration front-end for the `pid` block. It receives UART frames on a single `rx` line and validates each frame's sync byte, address range and checksum. It then performs the matching register write on the PID's active-low `write_enable` / `reg_addr` / `reg_data` port. This makes it the writer side of the PID register interface. The loader sits between the board UART pin and `pid`, so gains can be reprogrammed at run time without a reset.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be even and ≥ 4.
- `NUM_REGS`, 4: number of valid PID registers; addresses ≥ `NUM_REGS` are rejected.
- `TIMEOUT_CLKS`, 512: maximum clock gap between bytes of one frame.
- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idle high, 8N1, LSB first; asynchronous to `clock`.
- `write_enable`  out  1  active-low register write strobe to `pid`.
- `reg_addr`  out  16  register address; zero-extended from the frame's address byte.
- `reg_data`  out  16  register data, `{DATA_H, DATA_L}`.
- `busy`  out  1  high while a frame is partially received (parser not in HUNT).
- `frame_err`  out  1  one-cycle pulse for each rejected frame.
- `err_count`  out  8  saturating count of rejected frames.

## Operation
- **Reset values:** `write_enable`=1, `reg_addr`=0, `reg_data`=0, `busy`=0, `frame_err`=0, `err_count`=0. Both the receiver and the parser return to idle/HUNT; a partial frame is discarded.
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer that resets to 1.
- **UART receiver states:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronized `rx` of 0 enters START.
  - START: samples at `CLKS_PER_BIT/2`. If the line is high again, this is a glitch; return to IDLE with no byte and no error.
  - DATA: samples 8 bits, one every `CLKS_PER_BIT` clocks, at bit centre, LSB first.
  - STOP: samples the stop bit at its centre. A 1 pulses an internal `byte_valid` with the byte. A 0 is a framing error: the byte is dropped and the parser is forced to HUNT. A framing error counts as a rejected frame only if the parser was not in HUNT.
- **Frame format:** 0xA5, ADDR, DATA_H, DATA_L, CHK, where CHK = ADDR ^ DATA_H ^ DATA_L.
- **Parser states:** HUNT → ADDR → DH → DL → CHK → HUNT.
  - HUNT ignores every byte except 0xA5, with no error.
  - Outside HUNT, a byte value of 0xA5 is plain data; there is no resync.
- **On the CHK byte:**
  - Checksum matches and ADDR < `NUM_REGS`: commit the write.
  - Otherwise: pulse `frame_err` and increment `err_count`.
  - In both cases return to HUNT.
- **Timeout:** a clock counter restarts on every `byte_valid` and counts only while not in HUNT. Reaching `TIMEOUT_CLKS` forces HUNT, pulses `frame_err` and increments `err_count`.
- **`err_count`:** saturates at 255; it never wraps.
- **Simultaneous events:** a timeout and a `byte_valid` in the same cycle resolve as the byte (the timeout is suppressed). One frame produces at most one `frame_err` pulse.

## Timing
- A byte takes 10·`CLKS_PER_BIT` clocks on the line. `byte_valid` fires 9.5·`CLKS_PER_BIT` (+2 for sync) clocks after the start-bit falling edge.
- **Commit:** on the edge after the CHK `byte_valid`, `reg_addr` and `reg_data` are loaded and `write_enable` goes low for exactly one clock, then returns to 1.
  - `reg_addr` and `reg_data` are stable during the low cycle and hold until the next commit.
  - Rejected frames never change them.
- **Error pulse:** `frame_err` is high for one clock, on the edge after the decision. `err_count` updates on the same edge.
- **`busy`:** rises on the edge after the 0xA5 `byte_valid` and falls on the edge that returns the parser to HUNT.
- **Back-to-back frames:** supported with zero idle bits between them. The maximum write rate is one write per 50·`CLKS_PER_BIT` clocks.
- **Reset mid-write:** asserting `reset` while `write_enable` is low forces it to 1 immediately (asynchronously).

## Test plan
- **Valid frame:** send A5 01 00 0D 0C → `write_enable` low for exactly 1 cycle with `reg_addr`=0x0001 and `reg_data`=0x000D; `frame_err` stays 0 and `err_count`=0.
- **Hunt and data-byte A5:**
  - Send 00 FF A5 02 A5 00 A7 → one write with `reg_addr`=2, `reg_data`=0xA500.
  - The leading garbage bytes produce no error.
- **Bad checksum, then bad address:**
  - Send A5 03 12 34 00 → no write, one `frame_err` pulse, `err_count`=1; `reg_addr`/`reg_data` keep their previous values.
  - Then send A5 07 00 01 06 (ADDR ≥ 4) → no write, `err_count`=2.
- **Timeout:** send A5 01, then hold `rx` high for 600 clocks → `frame_err` pulse at 512 clocks after the second `byte_valid`, `busy` falls, `err_count`=1. A following valid frame A5 00 00 0E 0E writes addr 0, data 0x000E.
- **Framing error and start-bit glitch:**
  - Send A5 01 with the stop bit of 01 driven low → frame dropped, `err_count`=1, parser back in HUNT.
  - A 3-clock low glitch on idle `rx` produces no byte and no error.
- **Reset mid-frame and saturation:**
  - Pull `reset` low after A5 01 00 → all outputs return to reset values. The next full frame A5 01 00 0D 0C still writes correctly.
  - Separately, send 300 bad-checksum frames → `err_count` stays at 255.
